// File: rtl/asu_ddr5_cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module      : asu_ddr5_cfg_regfile
// Description : DDR5 PHY config register file. Host writes land in shadow
//               words; a commit copies shadow to active once the PHY is idle.
//               Optional read parity: define ASU_DDR5_REGFILE_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module asu_ddr5_cfg_regfile #(
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pADDR_WIDTH = 2,
    parameter logic        pCRC_MODE   = 1'b1,
    parameter logic [1:0]  pFREQ_RATIO = 2'b00
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [pADDR_WIDTH-1:0] wr_addr_i,
    input  logic [pDATA_WIDTH-1:0] wr_data_i,
    input  logic                   rd_en_i,
    input  logic [pADDR_WIDTH-1:0] rd_addr_i,
    output logic [pDATA_WIDTH-1:0] rd_data_o,
    output logic                   rd_valid_o,
    output logic                   rd_parity_err_o,
    output logic                   wr_err_o,
    input  logic                   commit_i,
    input  logic                   phy_idle_i,
    output logic                   commit_pending_o,
    output logic                   commit_done_o,
    output logic                   phy_CRC_mode_o,
    output logic [1:0]             dfi_freq_ratio_o
);

    localparam int unsigned            c_NUM_WORDS  = 2 ** pADDR_WIDTH;
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_CRC   = '0;
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_RATIO = pADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_COPY = 2'd2
    } state_t;

    function automatic logic [pDATA_WIDTH-1:0] f_reset_word(input int unsigned idx);
        logic [pDATA_WIDTH-1:0] word;
        word = '0;
        if (idx == 0) begin
            word[0] = pCRC_MODE;
        end else if (idx == 1) begin
            word[1:0] = pFREQ_RATIO;
        end
        return word;
    endfunction

    logic [pDATA_WIDTH-1:0] r_shadow [c_NUM_WORDS];
    logic [pDATA_WIDTH-1:0] r_rd_data;
    logic                   r_rd_valid;
    logic                   r_wr_err;
    state_t                 r_state;
    logic                   r_pending;
    logic                   r_done;
    logic                   r_active_crc;
    logic [1:0]             r_active_ratio;
    logic                   w_wr_reject;
    logic                   w_wr_accept;

    // The reserved ratio encoding 2'b11 must never reach the DFI converter.
    assign w_wr_reject = wr_en_i && (wr_addr_i == c_ADDR_RATIO) && (wr_data_i[1:0] == 2'b11);
    assign w_wr_accept = wr_en_i && !w_wr_reject;

    // Shadow storage and read port; the read samples the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_NUM_WORDS; i++) begin
                r_shadow[i] <= f_reset_word(i);
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_shadow[wr_addr_i] <= wr_data_i;
            end
            if (rd_en_i) begin
                r_rd_data <= r_shadow[rd_addr_i];
            end
            r_rd_valid <= rd_en_i;
            r_wr_err   <= w_wr_reject;
        end
    end

    // Commit FSM. Only the active bits that feed the PHY are held, since the
    // remaining active bits have no consumer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_pending      <= 1'b0;
            r_done         <= 1'b0;
            r_active_crc   <= pCRC_MODE;
            r_active_ratio <= pFREQ_RATIO;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (commit_i) begin
                        if (phy_idle_i) begin
                            r_state <= ST_COPY;
                        end else begin
                            r_state   <= ST_PEND;
                            r_pending <= 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    if (phy_idle_i) begin
                        r_state   <= ST_COPY;
                        r_pending <= 1'b0;
                    end
                end
                ST_COPY: begin
                    r_active_crc   <= r_shadow[c_ADDR_CRC][0];
                    r_active_ratio <= r_shadow[c_ADDR_RATIO][1:0];
                    r_done         <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

`ifdef ASU_DDR5_REGFILE_PARITY_EN
    logic r_parity [c_NUM_WORDS];
    logic r_rd_parity_err;

    // Even parity stored per shadow word and re-checked on every read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_NUM_WORDS; i++) begin
                r_parity[i] <= ^f_reset_word(i);
            end
            r_rd_parity_err <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_parity[wr_addr_i] <= ^wr_data_i;
            end
            r_rd_parity_err <= rd_en_i && ((^r_shadow[rd_addr_i]) != r_parity[rd_addr_i]);
        end
    end

    assign rd_parity_err_o = r_rd_parity_err;
`else
    assign rd_parity_err_o = 1'b0;
`endif

    assign rd_data_o        = r_rd_data;
    assign rd_valid_o       = r_rd_valid;
    assign wr_err_o         = r_wr_err;
    assign commit_pending_o = r_pending;
    assign commit_done_o    = r_done;
    assign phy_CRC_mode_o   = r_active_crc;
    assign dfi_freq_ratio_o = r_active_ratio;

endmodule
`default_nettype wire

// File: tb/tb_asu_ddr5_cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_asu_ddr5_cfg_regfile
// Description : Self-checking bench: directed scenarios plus random traffic
//               compared every cycle against a behavioural register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asu_ddr5_cfg_regfile;

    localparam int         DW        = 8;
    localparam int         AW        = 2;
    localparam int         NW        = 4;
    localparam logic       CRC_RST   = 1'b1;
    localparam logic [1:0] RATIO_RST = 2'b01;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, commit, phy_idle;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_parity_err, wr_err;
    logic          commit_pending, commit_done, crc_mode;
    logic [1:0]    freq_ratio;

    always #5 clk = ~clk;

    asu_ddr5_cfg_regfile #(
        .pDATA_WIDTH (DW),
        .pADDR_WIDTH (AW),
        .pCRC_MODE   (CRC_RST),
        .pFREQ_RATIO (RATIO_RST)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .wr_en_i          (wr_en),
        .wr_addr_i        (wr_addr),
        .wr_data_i        (wr_data),
        .rd_en_i          (rd_en),
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data),
        .rd_valid_o       (rd_valid),
        .rd_parity_err_o  (rd_parity_err),
        .wr_err_o         (wr_err),
        .commit_i         (commit),
        .phy_idle_i       (phy_idle),
        .commit_pending_o (commit_pending),
        .commit_done_o    (commit_done),
        .phy_CRC_mode_o   (crc_mode),
        .dfi_freq_ratio_o (freq_ratio)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: register words, plus a commit request that is either
    // waiting for idle or scheduled to land at the next edge.
    logic [DW-1:0] m_sh  [NW];
    logic [DW-1:0] m_act [NW];
    logic [DW-1:0] m_rdata;
    logic          m_valid, m_err, m_done, m_waiting, m_copy_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_sh[i] = '0;
        end
        m_sh[0][0]   = CRC_RST;
        m_sh[1][1:0] = RATIO_RST;
        m_act        = m_sh;
        m_rdata      = '0;
        m_valid      = 1'b0;
        m_err        = 1'b0;
        m_done       = 1'b0;
        m_waiting    = 1'b0;
        m_copy_next  = 1'b0;
    endtask

    task automatic model_step();
        logic [DW-1:0] snap [NW];
        logic          accept_now;
        if (rst) begin
            model_reset();
        end else begin
            snap   = m_sh;
            m_done = m_copy_next;
            if (m_copy_next) begin
                m_act = snap;
            end
            accept_now  = !m_copy_next && (m_waiting || commit);
            m_copy_next = accept_now && phy_idle;
            m_waiting   = accept_now && !phy_idle;
            m_valid     = rd_en;
            if (rd_en) begin
                m_rdata = snap[rd_addr];
            end
            m_err = wr_en && (wr_addr == 2'd1) && (wr_data[1:0] == 2'b11);
            if (wr_en && !m_err) begin
                m_sh[wr_addr] = wr_data;
            end
        end
    endtask

    task automatic compare_all();
        chk("rd_data", rd_data, m_rdata);
        chk("rd_valid", rd_valid, m_valid);
        chk("rd_parity_err", rd_parity_err, 1'b0);
        chk("wr_err", wr_err, m_err);
        chk("commit_pending", commit_pending, m_waiting);
        chk("commit_done", commit_done, m_done);
        chk("phy_CRC_mode", crc_mode, m_act[0][0]);
        chk("dfi_freq_ratio", freq_ratio, m_act[1][1:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic quiet();
        rst      = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        commit   = 1'b0;
        phy_idle = 1'b1;
        wr_addr  = '0;
        rd_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        model_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // T1: reset values
        chk("t1_crc", crc_mode, 1'b1);
        chk("t1_ratio", freq_ratio, 2'b01);
        read(2'd0);
        chk("t1_rd_w0", rd_data, 8'h01);
        read(2'd1);
        chk("t1_rd_w1", rd_data, 8'h01);

        // T2: commit with PHY idle
        write(2'd1, 8'h02);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t2_ratio_hold", freq_ratio, 2'b01);
        chk("t2_done_early", commit_done, 1'b0);
        tick();
        chk("t2_done", commit_done, 1'b1);
        chk("t2_ratio_new", freq_ratio, 2'b10);
        tick();
        chk("t2_done_pulse", commit_done, 1'b0);

        // T3: reserved ratio rejected
        do_reset();
        write(2'd1, 8'h03);
        chk("t3_wr_err", wr_err, 1'b1);
        tick();
        chk("t3_wr_err_pulse", wr_err, 1'b0);
        read(2'd1);
        chk("t3_rd_w1", rd_data, 8'h01);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("t3_done", commit_done, 1'b1);
        chk("t3_ratio", freq_ratio, 2'b01);

        // T4: commit waits for idle, write during the wait is included
        do_reset();
        phy_idle = 1'b0;
        commit   = 1'b1;
        tick();
        commit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                write(2'd0, 8'h00);
            end else begin
                tick();
            end
            chk("t4_pending", commit_pending, 1'b1);
        end
        chk("t4_crc_hold", crc_mode, 1'b1);
        phy_idle = 1'b1;
        tick();
        chk("t4_crc_copy_cycle", crc_mode, 1'b1);
        tick();
        chk("t4_crc_new", crc_mode, 1'b0);
        chk("t4_done", commit_done, 1'b1);

        // T5: read-before-write on the same address
        do_reset();
        rd_en   = 1'b1;
        rd_addr = 2'd2;
        write(2'd2, 8'hA5);
        chk("t5_rd_old", rd_data, 8'h00);
        read(2'd2);
        chk("t5_rd_new", rd_data, 8'hA5);

        // T6: reset aborts a pending commit
        do_reset();
        write(2'd0, 8'h00);
        write(2'd1, 8'h02);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("t6_pre_crc", crc_mode, 1'b0);
        chk("t6_pre_ratio", freq_ratio, 2'b10);
        phy_idle = 1'b0;
        commit   = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("t6_pending", commit_pending, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_pending_clr", commit_pending, 1'b0);
        chk("t6_crc_rst", crc_mode, 1'b1);
        chk("t6_ratio_rst", freq_ratio, 2'b01);
        phy_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_done", commit_done, 1'b0);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = AW'($urandom_range(0, NW - 1));
            wr_data  = DW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wr_addr      = 2'd1;
                wr_data[1:0] = 2'b11;
            end
            rd_en    = ($urandom_range(0, 1) == 1);
            rd_addr  = AW'($urandom_range(0, NW - 1));
            commit   = ($urandom_range(0, 7) == 0);
            phy_idle = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
